// File: rtl/l1c_mem_responder_pkg.sv
// Shared types and helpers for the L1 instruction-cache memory responder.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package l1c_mem_responder_pkg;

  localparam int CACHE_TYPE_BITS = 3;
  localparam int LAT_W           = 4;   // holds LATENCY values 0..15

  typedef enum logic [CACHE_TYPE_BITS-1:0] {
    CT_BYTE  = 3'b000,
    CT_HALF  = 3'b001,
    CT_WORD  = 3'b010,
    CT_UBYTE = 3'b100,
    CT_UHALF = 3'b101
  } cache_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } resp_state_e;

  // Byte lanes touched by a store; lane 0 is bits [7:0].
  function automatic logic [3:0] lane_mask(input logic [CACHE_TYPE_BITS-1:0] t,
                                           input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (t)
      CT_BYTE, CT_UBYTE: m = 4'b0001 << a;
      CT_HALF, CT_UHALF: m = a[1] ? 4'b1100 : 4'b0011;
      CT_WORD:           m = 4'b1111;
      default:           m = 4'b0000;
    endcase
    return m;
  endfunction

  // Unknown size encodings are treated like a misaligned store: no lanes written.
  function automatic logic misaligned(input logic [CACHE_TYPE_BITS-1:0] t,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (t)
      CT_BYTE, CT_UBYTE: bad = 1'b0;
      CT_HALF, CT_UHALF: bad = a[0];
      CT_WORD:           bad = (a != 2'b00);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Store data is replicated so the lane mask alone selects the bytes.
  function automatic logic [31:0] replicate(input logic [CACHE_TYPE_BITS-1:0] t,
                                            input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (t)
      CT_BYTE, CT_UBYTE: r = {4{d[7:0]}};
      CT_HALF, CT_UHALF: r = {2{d[15:0]}};
      default:           r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/l1c_mem_responder_if.sv
// Cache-to-memory refill port: request strobe, address/data/size, wait and read data.
// Latency: n/a (wiring only).
// Backpressure: I_wait from the responder stalls the cache; no ready on the request side.
// master = cache side, slave = memory responder.
interface l1c_mem_responder_if;
  import l1c_mem_responder_pkg::*;

  logic                       I_req;
  logic [31:0]                I_addr;
  logic                       I_write;
  logic [31:0]                I_in;
  logic [CACHE_TYPE_BITS-1:0] I_type;
  logic [31:0]                I_out;
  logic                       I_wait;
  logic                       proto_err;

  modport master (
    output I_req, I_addr, I_write, I_in, I_type,
    input  I_out, I_wait, proto_err
  );

  modport slave (
    input  I_req, I_addr, I_write, I_in, I_type,
    output I_out, I_wait, proto_err
  );

endinterface

// File: rtl/l1c_mem_responder_resp_word_ram.sv
// DEPTH x 32 word store with per-byte write enables and a registered read port.
// Latency: write commits at the edge it is presented; read data appears one edge after rd_en.
// Backpressure: none; every presented write/read is performed.
// Ports: clk/rst, wr_be/wr_idx/wr_dat (write), rd_en/rd_idx (read), rd_dat (held read register).
module resp_word_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               wr_be,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [31:0]              wr_dat,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [31:0]              rd_dat
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_dat_d;
  logic [31:0] rd_dat_q;

  // Contents survive reset on purpose: a store committed before reset stays visible.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/l1c_mem_responder.sv
// Fixed-latency word memory answering the L1 I-cache refill port.
// Latency: I_wait high for LATENCY cycles after acceptance, data on I_out the cycle after.
// Backpressure: I_wait stalls the cache; a request while busy is dropped and flags proto_err.
// Ports: clk, rst (sync, active-low), bus (slave side of l1c_mem_responder_if).
module l1c_mem_responder
  import l1c_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  l1c_mem_responder_if.slave   bus
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] LAT_CNT = LAT_W'(LATENCY);

  resp_state_e      state_d, state_q;
  logic [LAT_W-1:0] cnt_d,   cnt_q;
  logic [IDX_W-1:0] idx_d,   idx_q;
  logic             write_d, write_q;
  logic             perr_d,  perr_q;

  logic             accept;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_dat;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_dat;

  // Upper address bits alias onto the array; they are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^bus.I_addr[31:IDX_W+2];

  assign req_idx = bus.I_addr[IDX_W+1:2];
  assign accept  = rst && bus.I_req && (state_q != ST_BUSY);
  assign wr_dat  = replicate(bus.I_type, bus.I_in);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    perr_d  = perr_q;
    wr_be   = 4'b0000;
    rd_en   = 1'b0;
    rd_idx  = idx_q;

    case (state_q)
      ST_BUSY: begin
        if (bus.I_req) begin
          perr_d = 1'b1;
        end
        // <= 1 rather than == 1 so a stray zero count can never wedge the FSM.
        if (cnt_q <= LAT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          rd_en   = !write_q;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (!accept) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      idx_d   = req_idx;
      write_d = bus.I_write;
      // Stores commit immediately; only the response timing is delayed.
      if (bus.I_write) begin
        if (misaligned(bus.I_type, bus.I_addr[1:0])) begin
          perr_d = 1'b1;
        end else begin
          wr_be = lane_mask(bus.I_type, bus.I_addr[1:0]);
        end
      end
      if (LATENCY == 0) begin
        // Zero-latency build reads with the live address at the accepting edge.
        state_d = ST_RESP;
        rd_en   = !bus.I_write;
        rd_idx  = req_idx;
      end else begin
        state_d = ST_BUSY;
        cnt_d   = LAT_CNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      perr_q  <= perr_d;
    end
  end

  resp_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_be  (wr_be),
    .wr_idx (req_idx),
    .wr_dat (wr_dat),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat)
  );

  assign bus.I_wait    = (state_q == ST_BUSY);
  assign bus.I_out     = rd_dat;
  assign bus.proto_err = perr_q;

endmodule

// File: tb/tb_l1c_mem_responder.sv
// Scoreboard bench for l1c_mem_responder: a LATENCY=2 and a LATENCY=0 instance.
// Stimulus pushes cycle-stamped expectations; a negedge monitor pops and compares.
module tb_l1c_mem_responder;
  import l1c_mem_responder_pkg::*;

  localparam int K_OUT  = 0;
  localparam int K_WAIT = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sbq[$];
  exp_t it;
  logic [31:0] act;
  logic [31:0] held [2];

  l1c_mem_responder_if if_l2 ();
  l1c_mem_responder_if if_l0 ();

  l1c_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(if_l2));
  l1c_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut_l0 (.clk(clk), .rst(rst), .bus(if_l0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] probe(input int d, input int k);
    logic [31:0] v;
    v = '0;
    if (d == 0) begin
      case (k)
        K_OUT:   v = if_l2.I_out;
        K_WAIT:  v = {31'b0, if_l2.I_wait};
        default: v = {31'b0, if_l2.proto_err};
      endcase
    end else begin
      case (k)
        K_OUT:   v = if_l0.I_out;
        K_WAIT:  v = {31'b0, if_l0.I_wait};
        default: v = {31'b0, if_l0.proto_err};
      endcase
    end
    return v;
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      it  = sbq.pop_front();
      act = probe(it.dut, it.kind);
      n_cmp++;
      if (act !== it.val) begin
        n_bad++;
        $display("FAIL %s (dut%0d cyc %0d): got %h, want %h", it.name, it.dut, cyc, act, it.val);
      end
    end
  end

  task automatic push(input int c, input int d, input int k, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.dut = d; e.kind = k; e.val = v; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic drive(input int d, input logic req, input logic wr, input logic [31:0] addr,
                       input logic [31:0] dat, input logic [2:0] t);
    if (d == 0) begin
      if_l2.I_req = req; if_l2.I_write = wr; if_l2.I_addr = addr; if_l2.I_in = dat; if_l2.I_type = t;
    end else begin
      if_l0.I_req = req; if_l0.I_write = wr; if_l0.I_addr = addr; if_l0.I_in = dat; if_l0.I_type = t;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_reset_state(input string nm);
    for (int d = 0; d < 2; d++) begin
      push(cyc, d, K_WAIT, 32'h0, {nm, "/wait"});
      push(cyc, d, K_OUT,  32'h0, {nm, "/out"});
      push(cyc, d, K_PERR, 32'h0, {nm, "/perr"});
    end
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    held[0] = '0;
    held[1] = '0;
    push_reset_state(nm);
  endtask

  // Issues one access in the current cycle and returns in its response cycle,
  // so a following call is a back-to-back request.
  task automatic access(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] dat, input logic [2:0] t,
                        input logic [31:0] exp_rd, input string nm);
    int t0;
    int lat;
    t0  = cyc;
    lat = lat_of(d);
    drive(d, 1'b1, wr, addr, dat, t);
    push(t0, d, K_WAIT, 32'h0, {nm, "/wait_acc"});
    for (int k = 1; k <= lat; k++) push(t0 + k, d, K_WAIT, 32'h1, {nm, "/wait_busy"});
    push(t0 + lat + 1, d, K_WAIT, 32'h0, {nm, "/wait_resp"});
    if (!wr) held[d] = exp_rd;
    push(t0 + lat + 1, d, K_OUT, held[d], {nm, "/out"});
    step(1);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    step(lat);
  endtask

  initial begin
    int t0;
    n_cmp = 0;
    n_bad = 0;
    held[0] = '0;
    held[1] = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

    // Reset values
    do_reset("reset");
    step(1);

    // Word write then read at LATENCY=2; the write must not disturb I_out
    access(0, 1'b1, 32'h40, 32'hDEADBEEF, CT_WORD, 32'h0, "wr40");
    access(0, 1'b0, 32'h40, 32'h0, CT_WORD, 32'hDEADBEEF, "rd40");
    step(2);

    // Line fill: preload, then four back-to-back reads 3 cycles apart
    access(0, 1'b1, 32'h100, 32'h11111111, CT_WORD, 32'h0, "pre100");
    access(0, 1'b1, 32'h104, 32'h22222222, CT_WORD, 32'h0, "pre104");
    access(0, 1'b1, 32'h108, 32'h33333333, CT_WORD, 32'h0, "pre108");
    access(0, 1'b1, 32'h10C, 32'h44444444, CT_WORD, 32'h0, "pre10C");
    step(1);
    access(0, 1'b0, 32'h100, 32'h0, CT_WORD, 32'h11111111, "fill0");
    access(0, 1'b0, 32'h104, 32'h0, CT_WORD, 32'h22222222, "fill1");
    access(0, 1'b0, 32'h108, 32'h0, CT_WORD, 32'h33333333, "fill2");
    access(0, 1'b0, 32'h10C, 32'h0, CT_WORD, 32'h44444444, "fill3");
    step(1);

    // Byte store into lane 2, then a misaligned half store that must be dropped
    access(0, 1'b1, 32'h40, 32'h00000000, CT_WORD, 32'h0, "clr40");
    access(0, 1'b1, 32'h42, 32'h000000AB, CT_BYTE, 32'h0, "byte42");
    access(0, 1'b0, 32'h40, 32'h0, CT_WORD, 32'h00AB0000, "rdbyte");
    push(cyc, 0, K_PERR, 32'h0, "perr_clean");
    step(1);
    t0 = cyc;
    access(0, 1'b1, 32'h41, 32'h00001234, CT_HALF, 32'h0, "half41");
    push(cyc, 0, K_PERR, 32'h1, "perr_misalign");
    step(1);
    access(0, 1'b0, 32'h40, 32'h0, CT_WORD, 32'h00AB0000, "rd_after_mis");
    step(1);

    // Request during BUSY: ignored (no store, no restart) and flagged
    do_reset("reset2");
    step(1);
    t0 = cyc;
    drive(0, 1'b1, 1'b0, 32'h100, 32'h0, CT_WORD);
    push(t0, 0, K_WAIT, 32'h0, "viol/wait_acc");
    step(1);
    drive(0, 1'b1, 1'b1, 32'h104, 32'h00000BAD, CT_WORD);
    push(t0 + 1, 0, K_WAIT, 32'h1, "viol/wait1");
    step(1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    push(t0 + 2, 0, K_WAIT, 32'h1, "viol/wait2");
    push(t0 + 2, 0, K_PERR, 32'h1, "viol/perr");
    step(1);
    held[0] = 32'h11111111;
    push(t0 + 3, 0, K_WAIT, 32'h0, "viol/wait_resp");
    push(t0 + 3, 0, K_OUT, 32'h11111111, "viol/out");
    step(1);
    access(0, 1'b0, 32'h104, 32'h0, CT_WORD, 32'h22222222, "viol/nostore");
    step(1);

    // Reset in the middle of a store's BUSY window
    t0 = cyc;
    drive(0, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D, CT_WORD);
    push(t0, 0, K_WAIT, 32'h0, "rstbusy/wait_acc");
    step(1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    push(t0 + 1, 0, K_WAIT, 32'h1, "rstbusy/wait1");
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    held[0] = '0;
    held[1] = '0;
    push(t0 + 2, 0, K_WAIT, 32'h0, "rstbusy/idle");
    push(t0 + 2, 0, K_OUT,  32'h0, "rstbusy/out");
    push(t0 + 2, 0, K_PERR, 32'h0, "rstbusy/perr");
    step(1);
    access(0, 1'b0, 32'h80, 32'h0, CT_WORD, 32'hCAFEF00D, "rstbusy/kept");
    step(1);

    // LATENCY=0 instance: no wait, data the next cycle, wrap, uhalf store
    access(1, 1'b1, 32'h10, 32'h5A5A5A5A, CT_WORD, 32'h0, "l0/wr10");
    access(1, 1'b0, 32'h10, 32'h0, CT_WORD, 32'h5A5A5A5A, "l0/rd10");
    step(1);
    access(1, 1'b1, 32'h1010, 32'h0F0F1234, CT_WORD, 32'h0, "l0/wrap_wr");
    access(1, 1'b0, 32'h80000010, 32'h0, CT_WORD, 32'h0F0F1234, "l0/wrap_rd");
    access(1, 1'b1, 32'h20, 32'h00000000, CT_WORD, 32'h0, "l0/clr20");
    access(1, 1'b1, 32'h22, 32'hFFFFBEEF, CT_UHALF, 32'h0, "l0/uhalf");
    access(1, 1'b0, 32'h20, 32'h0, CT_WORD, 32'hBEEF0000, "l0/rd20");
    push(cyc, 1, K_PERR, 32'h0, "l0/perr");
    step(3);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
